// File: rtl/decimal_ascii_formatter.sv
// decimal_ascii_formatter: binary value -> NUL-terminated decimal ASCII.
// Optional macro SIGNED_EN: two's complement input with a leading "-".
// Ports: clk, rst_n (async, active-low); start/value request the
//   conversion; busy while converting/emitting; char_out/char_valid/
//   char_ready/char_last form the byte stream; done pulses at the end.

module decimal_ascii_formatter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    output logic             busy,
    output logic [7:0]       char_out,
    output logic             char_valid,
    input  logic             char_ready,
    output logic             char_last,
    output logic             done
);

    localparam int DIGITS = (WIDTH * 77) / 256 + 1;
    localparam int SPW    = $clog2(DIGITS + 1);
    localparam int CW     = $clog2(WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        DIVIDE,
        PUSH,
        EMIT_SIGN,
        EMIT_DIGIT,
        EMIT_NUL,
        FINISH
    } state_t;

    state_t state;
    state_t state_nx;

    logic [WIDTH-1:0] quo;
    logic [3:0]       rem;
    logic [CW-1:0]    cnt;
    logic [3:0]       lifo [DIGITS];
    logic [SPW-1:0]   sp;
    logic [SPW-1:0]   top_idx;
    logic             neg;
    logic [WIDTH-1:0] mag_in;
    logic [4:0]       trial;
    logic             qbit;
    logic [3:0]       rem_nx;
    logic             last_div;

`ifdef SIGNED_EN
    logic neg_in;
    assign neg_in = value[WIDTH-1];
    assign mag_in = neg_in ? (~value + 1'b1) : value;
`else
    assign neg    = 1'b0;
    assign mag_in = value;
`endif

    // Restoring step: remainder stays below 10, so the 4-bit
    // subtraction wraps to the correct result.
    assign trial    = {rem, quo[WIDTH-1]};
    assign qbit     = (trial >= 5'd10);
    assign rem_nx   = qbit ? (trial[3:0] - 4'd10) : trial[3:0];
    assign last_div = (cnt == CW'(WIDTH - 1));
    assign top_idx  = sp - SPW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        busy       = 1'b1;
        char_out   = 8'h00;
        char_valid = 1'b0;
        char_last  = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nx = DIVIDE;
            end
            DIVIDE: begin
                if (last_div) state_nx = PUSH;
            end
            PUSH: begin
                if (quo != '0) state_nx = DIVIDE;
                else if (neg) state_nx = EMIT_SIGN;
                else state_nx = EMIT_DIGIT;
            end
`ifdef SIGNED_EN
            EMIT_SIGN: begin
                char_valid = 1'b1;
                char_out   = 8'h2d;
                if (char_ready) state_nx = EMIT_DIGIT;
            end
`endif
            EMIT_DIGIT: begin
                char_valid = 1'b1;
                char_out   = {4'h3, lifo[top_idx]};
                if (char_ready && sp == SPW'(1))
                    state_nx = EMIT_NUL;
            end
            EMIT_NUL: begin
                char_valid = 1'b1;
                char_last  = 1'b1;
                if (char_ready) state_nx = FINISH;
            end
            FINISH: begin
                busy     = 1'b0;
                done     = 1'b1;
                state_nx = start ? DIVIDE : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo <= '0;
            rem <= '0;
            cnt <= '0;
            sp  <= '0;
`ifdef SIGNED_EN
            neg <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, FINISH: begin
                    if (start) begin
                        quo <= mag_in;
                        rem <= '0;
                        cnt <= '0;
                        sp  <= '0;
`ifdef SIGNED_EN
                        neg <= neg_in;
`endif
                    end
                end
                DIVIDE: begin
                    quo <= {quo[WIDTH-2:0], qbit};
                    rem <= rem_nx;
                    cnt <= cnt + 1'b1;
                end
                PUSH: begin
                    sp  <= sp + 1'b1;
                    rem <= '0;
                    cnt <= '0;
                end
                EMIT_DIGIT: begin
                    if (char_ready) sp <= sp - 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Digit storage needs no reset; the stack pointer defines
    // which entries are live.
    always_ff @(posedge clk) begin
        if (state == PUSH) lifo[sp] <= rem;
    end

endmodule

// File: tb/tb_decimal_ascii_formatter.sv
// tb_decimal_ascii_formatter: random and directed stimulus checked
// against a string-level decimal formatting model.

module tb_decimal_ascii_formatter;

    localparam int W      = 32;
    localparam int WD_MAX = 1200;

    typedef logic [7:0] bq_t[$];

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  value;
    logic          busy;
    logic [7:0]    char_out;
    logic          char_valid;
    logic          char_ready;
    logic          char_last;
    logic          done;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    bq_t exp_q;
    bit  m_busy = 0;
    bit  m_done = 0;
    bit  first_pend = 0;
    bit  pinned = 0;
    bit  hs_nul;
    int  t0 = 0;
    int  lat = 0;
    int  wd = 0;

    decimal_ascii_formatter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .value     (value),
        .busy      (busy),
        .char_out  (char_out),
        .char_valid(char_valid),
        .char_ready(char_ready),
        .char_last (char_last),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic bq_t fmt(input logic [W-1:0] v);
        bq_t    r;
        longint m;
        bit     ng;
        ng = 0;
        m  = longint'(v);
`ifdef SIGNED_EN
        if (v[W-1]) begin
            ng = 1;
            m  = 64'sd4294967296 - m;
        end
`endif
        do begin
            r.push_front(8'(48 + m % 10));
            m = m / 10;
        end while (m != 0);
        if (ng) r.push_front(8'h2d);
        r.push_back(8'h00);
        return r;
    endfunction

    function automatic int lat_of(input bq_t q);
        int d = 0;
        foreach (q[i]) if (q[i] >= 8'h30 && q[i] <= 8'h39) d++;
        return d * (W + 1) + 1;
    endfunction

    function automatic string qs(input bq_t q);
        string s = "";
        foreach (q[i]) s = {s, $sformatf("%02x", q[i])};
        return s;
    endfunction

    task automatic chk(input string nm, input longint act,
                       input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic chks(input string nm, input string act,
                        input string exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %s expected %s", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_busy", busy, 0);
            chk("rst_valid", char_valid, 0);
            chk("rst_char", char_out, 0);
            chk("rst_last", char_last, 0);
            chk("rst_done", done, 0);
            exp_q.delete();
            m_busy     = 0;
            m_done     = 0;
            first_pend = 0;
            wd         = 0;
        end else begin
            if (!pinned) begin
                chks("pin_zero", qs(fmt(0)), "3000");
                chks("pin_12345", qs(fmt(12345)), "313233343500");
                chks("pin_907", qs(fmt(907)), "39303700");
                chk("pin_lat0", lat_of(fmt(0)), 34);
                chk("pin_lat12345", lat_of(fmt(12345)), 166);
`ifdef SIGNED_EN
                chks("pin_min", qs(fmt(32'h80000000)),
                     "2d3231343734383336343800");
                chks("pin_m1", qs(fmt(32'hFFFFFFFF)), "2d3100");
`else
                chks("pin_min", qs(fmt(32'h80000000)),
                     "3231343734383336343800");
                chks("pin_max", qs(fmt(32'hFFFFFFFF)),
                     "3432393439363732393500");
`endif
                pinned = 1;
            end
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            hs_nul = 0;
            if (char_valid) begin
                if (exp_q.size() == 0) begin
                    chk("valid_idle", char_valid, 0);
                end else begin
                    chk("char", char_out, exp_q[0]);
                    chk("last", char_last, exp_q.size() == 1);
                    if (first_pend) begin
                        chk("latency", cyc - t0, lat);
                        first_pend = 0;
                    end
                    if (char_ready) begin
                        void'(exp_q.pop_front());
                        if (exp_q.size() == 0) hs_nul = 1;
                    end
                end
            end else if (m_busy && !first_pend && exp_q.size() > 0) begin
                chk("valid_gap", char_valid, 1);
            end
            m_done = 0;
            if (m_busy) wd++;
            else wd = 0;
            if (wd > WD_MAX) begin
                checks++;
                errors++;
                $display("FAIL watchdog: busy for %0d cycles, limit %0d",
                         wd, WD_MAX);
                exp_q.delete();
                m_busy     = 0;
                first_pend = 0;
                wd         = 0;
            end
            if (start && !m_busy) begin
                exp_q      = fmt(value);
                lat        = lat_of(exp_q);
                t0         = cyc;
                first_pend = 1;
                m_busy     = 1;
            end
            if (hs_nul) begin
                m_busy = 0;
                m_done = 1;
            end
        end
    end

    task automatic run(input logic [W-1:0] v, input int mode);
        int hold = 0;
        int n = 0;
        start = 1'b1;
        value = v;
        @(posedge clk); #1;
        start = 1'b0;
        value = $urandom;
        while (m_busy && n < 1500) begin
            case (mode)
                0: char_ready = 1'b1;
                1: char_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (char_valid && char_out == 8'h30 && hold < 3) begin
                        char_ready = 1'b0;
                        hold++;
                    end else begin
                        char_ready = 1'b1;
                    end
                end
            endcase
            @(posedge clk); #1;
            n++;
        end
        char_ready = 1'b1;
    endtask

    initial begin
        int n;
        int gap;
        logic [W-1:0] v;
        rst_n      = 1'b0;
        start      = 1'b0;
        value      = '0;
        char_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        run(32'd0, 0);
        run(32'd12345, 0);
        run(32'h80000000, 0);
        run(32'hFFFFFFFF, 0);
        run(32'd907, 2);

        start = 1'b1;
        value = 32'd42;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 start = 1'b1;
        value = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (m_busy && n < 1500) begin
            @(posedge clk); #1;
            n++;
        end

        start = 1'b1;
        value = 32'd12345;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!(char_valid && char_out == 8'h32) && n < 1500) begin
            @(posedge clk); #1;
            n++;
        end
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        run(32'd8, 0);

        for (int i = 0; i < 40; i++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clk); #1;
            end
            case ($urandom_range(0, 3))
                0: v = $urandom;
                1: v = $urandom_range(0, 99);
                2: v = {1'b1, 31'($urandom)};
                default: v = $urandom_range(0, 10);
            endcase
            run(v, 1);
        end

        repeat (5) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
